// File: rtl/fib_stack_engine.sv
// ============================================================================
// fib_stack_engine : stack-driven Fibonacci/Lucas engine with start/done
// handshake, saturating result and stack-overflow abort.
// Optional: FIB_CYCLE_COUNT_EN adds a 16-bit run-length output `cycles`.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fib_stack_engine #(
  parameter int WORDSIZE = 10,
  parameter int NWIDTH   = 5,
  parameter int DEPTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NWIDTH-1:0]   n_in,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result,
  output logic                overflow,
  output logic                stack_err
`ifdef FIB_CYCLE_COUNT_EN
  ,
  output logic [15:0]         cycles
`endif
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORDSIZE:0] ACC_MAX = {1'b0, {WORDSIZE{1'b1}}};
  localparam logic [WORDSIZE:0] ACC_ONE = 1;
  localparam logic [WORDSIZE:0] ACC_TWO = 2;
  localparam logic [SPW-1:0]    SP_ONE  = 1;
  localparam logic [SPW-1:0]    SP_FULL = DEPTH[SPW-1:0];

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic [WORDSIZE:0]   acc_q, acc_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;
  logic [WORDSIZE-1:0] result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                serr_q, serr_d;
  logic [15:0]         cyc_q, cyc_d;
  logic [NWIDTH-1:0]   stack_q [DEPTH];

  logic                w_accept;
  logic                w_push;
  logic [SPW-1:0]      w_sp_m1;
  logic [IDXW-1:0]     w_top_idx;
  logic [IDXW-1:0]     w_push_idx;
  logic [NWIDTH-1:0]   w_k;
  logic                w_k_ge2;
  logic [WORDSIZE:0]   w_leaf;
  logic [WORDSIZE:0]   w_sum;

  assign w_sp_m1    = sp_q - SP_ONE;
  assign w_top_idx  = w_sp_m1[IDXW-1:0];
  assign w_push_idx = sp_q[IDXW-1:0];
  assign w_k        = stack_q[w_top_idx];
  assign w_k_ge2    = (w_k[NWIDTH-1:1] != '0);
  assign w_leaf     = w_k[0] ? ACC_ONE : (mode_q ? ACC_TWO : '0);
  assign w_sum      = acc_q + w_leaf;

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    serr_d   = serr_q;
    cyc_d    = cyc_q;
    w_accept = 1'b0;
    w_push   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          state_d  = S_RUN;
          sp_d     = SP_ONE;
          acc_d    = '0;
          mode_d   = mode;
          result_d = '0;
          ovf_d    = 1'b0;
          serr_d   = 1'b0;
          cyc_d    = '0;
        end
      end
      S_RUN: begin
        if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
        if (w_k_ge2) begin
          // Pop k and push k-1, k-2: occupancy grows by one, so a full stack aborts.
          if (sp_q == SP_FULL) begin
            serr_d   = 1'b1;
            result_d = '0;
            done_d   = 1'b1;
            sp_d     = '0;
            state_d  = S_IDLE;
          end else begin
            w_push = 1'b1;
            sp_d   = sp_q + SP_ONE;
          end
        end else begin
          if (w_sum > ACC_MAX) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = w_sum;
          end
          sp_d = w_sp_m1;
          if (sp_q == SP_ONE) begin
            result_d = acc_d[WORDSIZE-1:0];
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sp_q     <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      serr_q   <= serr_d;
      cyc_q    <= cyc_d;
    end
  end

  // Stack storage needs no reset: the pointer defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      stack_q[0] <= n_in;
    end else if (w_push) begin
      stack_q[w_top_idx]  <= w_k - NWIDTH'(1);
      stack_q[w_push_idx] <= w_k - NWIDTH'(2);
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign stack_err = serr_q;

`ifdef FIB_CYCLE_COUNT_EN
  assign cycles = cyc_q;
`else
  logic w_cyc_unused;
  assign w_cyc_unused = ^cyc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fib_stack_engine.sv
// Directed bench for fib_stack_engine: default instance plus a DEPTH=4 instance.
`default_nettype none

module tb_fib_stack_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       st  = 1'b0;
  logic [4:0] nn  = '0;
  logic       md  = 1'b0;
  logic       sel_b = 1'b0;

  logic       a_start, b_start;
  logic       a_busy, a_done, a_ovf, a_serr;
  logic       b_busy, b_done, b_ovf, b_serr;
  logic [9:0] a_res, b_res;
`ifdef FIB_CYCLE_COUNT_EN
  logic [15:0] a_cycles, b_cycles;
`endif

  logic       busy_m, done_m, ovf_m, serr_m;
  logic [9:0] res_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign a_start = st & ~sel_b;
  assign b_start = st & sel_b;
  assign busy_m  = sel_b ? b_busy : a_busy;
  assign done_m  = sel_b ? b_done : a_done;
  assign ovf_m   = sel_b ? b_ovf  : a_ovf;
  assign serr_m  = sel_b ? b_serr : a_serr;
  assign res_m   = sel_b ? b_res  : a_res;

  fib_stack_engine dut (
    .clk(clk), .rst(rst), .start(a_start), .n_in(nn), .mode(md),
    .busy(a_busy), .done(a_done), .result(a_res), .overflow(a_ovf), .stack_err(a_serr)
`ifdef FIB_CYCLE_COUNT_EN
    , .cycles(a_cycles)
`endif
  );

  fib_stack_engine #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(b_start), .n_in(nn), .mode(md),
    .busy(b_busy), .done(b_done), .result(b_res), .overflow(b_ovf), .stack_err(b_serr)
`ifdef FIB_CYCLE_COUNT_EN
    , .cycles(b_cycles)
`endif
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request and wait for done; lat = edges from accept to done.
  task automatic run_req(input bit selb, input logic [4:0] n, input logic m,
                         input bit disturb, output int lat);
    int busy_drop;
    busy_drop = 0;
    sel_b = selb;
    @(negedge clk);
    st = 1'b1; nn = n; md = m;
    @(posedge clk); #1;
    st  = 1'b0;
    lat = 0;
    while (!done_m && lat < 6000) begin
      if (!busy_m) busy_drop++;
      if (disturb) begin
        if (lat >= 3 && lat <= 20) begin
          st = lat[0]; nn = lat[4:0]; md = ~md;
        end else begin
          st = 1'b0;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    st = 1'b0;
    check_val("done_seen", int'(done_m), 1);
    check_val("busy_during_run", busy_drop, 0);
    check_val("busy_at_done", int'(busy_m), 0);
  endtask

  task automatic check_done_drop();
    @(posedge clk); #1;
    check_val("done_one_cycle", int'(done_m), 0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check_val("rst_busy", int'(a_busy), 0);
    check_val("rst_done", int'(a_done), 0);
    check_val("rst_result", int'(a_res), 0);
    check_val("rst_ovf", int'(a_ovf), 0);
    check_val("rst_serr", int'(a_serr), 0);
    rst = 1'b1;

    // Fibonacci n=10
    run_req(1'b0, 5'd10, 1'b0, 1'b0, lat);
    check_val("fib10_lat", lat, 177);
    check_val("fib10_res", int'(res_m), 55);
    check_val("fib10_ovf", int'(ovf_m), 0);
    check_val("fib10_serr", int'(serr_m), 0);
`ifdef FIB_CYCLE_COUNT_EN
    check_val("fib10_cycles", int'(a_cycles), 177);
`endif
    check_done_drop();
    repeat (3) @(posedge clk);
    #1 check_val("fib10_hold", int'(res_m), 55);

    // Lucas n=10 with disturbances mid-run
    run_req(1'b0, 5'd10, 1'b1, 1'b1, lat);
    check_val("luc10_lat", lat, 177);
    check_val("luc10_res", int'(res_m), 123);
    check_done_drop();

    run_req(1'b0, 5'd0, 1'b1, 1'b0, lat);
    check_val("luc0_lat", lat, 1);
    check_val("luc0_res", int'(res_m), 2);

    run_req(1'b0, 5'd1, 1'b0, 1'b0, lat);
    check_val("fib1_lat", lat, 1);
    check_val("fib1_res", int'(res_m), 1);

    run_req(1'b0, 5'd16, 1'b0, 1'b0, lat);
    check_val("fib16_lat", lat, 3193);
    check_val("fib16_res", int'(res_m), 987);
    check_val("fib16_ovf", int'(ovf_m), 0);

    run_req(1'b0, 5'd17, 1'b0, 1'b0, lat);
    check_val("fib17_lat", lat, 5167);
    check_val("fib17_res", int'(res_m), 1023);
    check_val("fib17_ovf", int'(ovf_m), 1);

    // DEPTH=4 instance
    run_req(1'b1, 5'd6, 1'b0, 1'b0, lat);
    check_val("d4_fib6_lat", lat, 25);
    check_val("d4_fib6_res", int'(res_m), 8);
    check_val("d4_fib6_serr", int'(serr_m), 0);

    run_req(1'b1, 5'd8, 1'b0, 1'b0, lat);
    check_val("d4_fib8_lat", lat, 4);
    check_val("d4_fib8_serr", int'(serr_m), 1);
    check_val("d4_fib8_res", int'(res_m), 0);
    check_done_drop();

    // Back-to-back with start held across done
    sel_b = 1'b0;
    @(negedge clk);
    st = 1'b1; nn = 5'd1; md = 1'b0;
    @(posedge clk); #1;
    nn = 5'd0; md = 1'b1;
    @(posedge clk); #1;
    check_val("b2b_first_done", int'(a_done), 1);
    check_val("b2b_first_res", int'(a_res), 1);
    @(posedge clk); #1;
    st = 1'b0;
    check_val("b2b_second_busy", int'(a_busy), 1);
    check_val("b2b_second_done_low", int'(a_done), 0);
    @(posedge clk); #1;
    check_val("b2b_second_done", int'(a_done), 1);
    check_val("b2b_second_res", int'(a_res), 2);

    // Asynchronous reset mid-run after a run left result=55
    run_req(1'b0, 5'd10, 1'b0, 1'b0, lat);
    @(negedge clk);
    st = 1'b1; nn = 5'd10; md = 1'b0;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("arst_busy", int'(a_busy), 0);
    check_val("arst_result", int'(a_res), 0);
    check_val("arst_done", int'(a_done), 0);
    @(negedge clk);
    rst = 1'b1;
    run_req(1'b0, 5'd1, 1'b0, 1'b0, lat);
    check_val("post_rst_lat", lat, 1);
    check_val("post_rst_res", int'(res_m), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
